// File: rtl/mest_pro_display_scan.sv
`timescale 1ns/1ps
// Display word capture FIFO with hold-time sequencing and a multiplexed,
// active-low hex seven-segment scanner.
module mest_pro_display_scan #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic                            clk,
  input  logic                            i_reset,
  input  logic                            i_clear,
  input  logic                            i_valid,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic                            i_all_done,
  output logic [DATA_WIDTH/4-1:0]         o_anode,
  output logic [6:0]                      o_segments,
  output logic                            o_dp,
  output logic                            o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
  output logic                            o_busy
);

  localparam int unsigned NUM_DIGITS = DATA_WIDTH / 4;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, WAIT} state_t;

  state_t                state_q, state_n;
  logic [HW-1:0]         hold_q, hold_n;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_n;
  logic [DATA_WIDTH-1:0] disp_q;
  logic [RW-1:0]         refresh_q;
  logic [IW-1:0]         idx_q;
  logic                  pop, push, full, empty;
  logic [3:0]            digit_c;

  assign full    = (o_fifo_count == CW'(FIFO_DEPTH));
  assign empty   = (o_fifo_count == '0);
  assign push    = i_valid && !i_clear && (!full || pop);
  assign digit_c = 4'(disp_q >> {idx_q, 2'b00});

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // State and hold counter registers.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
    end
  end

  // Sequencing: decide when to pop the next word and how long to hold it.
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_n  = '0;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          hold_n = '0;
          if (!empty) pop = 1'b1;
          else        state_n = WAIT;
        end else begin
          hold_n = hold_q + HW'(1);
        end
      end
      WAIT: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_n  = '0;
          state_n = SHOW;
        end
      end
      default: state_n = IDLE;
    endcase
    if (i_clear) begin
      state_n = IDLE;
      hold_n  = '0;
      pop     = 1'b0;
    end
  end

  // Next occupancy, accounting for simultaneous push and pop.
  always_comb begin
    count_n = o_fifo_count;
    case ({push, pop})
      2'b10:   count_n = o_fifo_count + CW'(1);
      2'b01:   count_n = o_fifo_count - CW'(1);
      default: count_n = o_fifo_count;
    endcase
    if (i_clear) count_n = '0;
  end

  // FIFO storage; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // FIFO pointers, occupancy, display register and sticky overflow.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_count <= '0;
      disp_q       <= '0;
      o_overflow   <= 1'b0;
    end else if (i_clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_count <= '0;
      disp_q       <= '0;
      o_overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        disp_q <= mem[rd_ptr];
      end
      o_fifo_count <= count_n;
      if (i_valid && !push) o_overflow <= 1'b1;
    end
  end

  // Free-running digit scanner.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      refresh_q <= refresh_q + RW'(1);
    end
  end

  // Registered pin drive: blank in IDLE, otherwise the selected digit.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_anode    <= '1;
      o_segments <= 7'h7F;
      o_dp       <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      o_busy <= (state_n != IDLE) || (count_n != '0);
      o_dp   <= !(i_all_done && (idx_q == '0) && (state_q != IDLE));
      if (state_q == IDLE) begin
        o_anode    <= '1;
        o_segments <= 7'h7F;
      end else begin
        o_anode    <= ~(NUM_DIGITS'(1) << idx_q);
        o_segments <= hex7(digit_c);
      end
    end
  end

endmodule

// File: tb/tb_mest_pro_display_scan.sv
`timescale 1ns/1ps
// Directed self-checking bench for mest_pro_display_scan.
module tb_mest_pro_display_scan;

  logic        clk = 1'b0;
  logic        i_reset, i_clear, i_valid, i_all_done;
  logic [15:0] i_data;
  logic [3:0]  o_anode;
  logic [6:0]  o_segments;
  logic        o_dp, o_overflow, o_busy;
  logic [2:0]  o_fifo_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb[$];

  mest_pro_display_scan #(
    .DATA_WIDTH(16), .FIFO_DEPTH(4), .REFRESH_DIV(4), .HOLD_CYCLES(8)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_clear(i_clear), .i_valid(i_valid),
    .i_data(i_data), .i_all_done(i_all_done), .o_anode(o_anode),
    .o_segments(o_segments), .o_dp(o_dp), .o_overflow(o_overflow),
    .o_fifo_count(o_fifo_count), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = 7'b1000000;  4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;  4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;  4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;  4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;  4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;  default: seg_of = 7'b0001110;
    endcase
  endfunction

  // One full 16-cycle scan: every slot must show its digit of w.
  task automatic scan_check(input logic [15:0] w, input logic done);
    logic [3:0] seen;
    seen = 4'h0;
    for (int c = 0; c < 16; c++) begin
      step();
      chk("anode_onehot", 32'($onehot(~o_anode)), 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (!o_anode[k]) begin
          seen[k] = 1'b1;
          chk($sformatf("seg_digit%0d", k), o_segments, seg_of(w[4*k +: 4]));
          chk($sformatf("dp_digit%0d", k), o_dp, (done && k == 0) ? 1'b0 : 1'b1);
        end
      end
    end
    chk("scan_all_digits", seen, 4'hF);
  endtask

  initial begin
    int peak, last;
    logic [15:0] prev, exp_w;

    i_reset = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_all_done = 1'b0; i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", o_anode, 4'hF);
    chk("rst_seg", o_segments, 7'h7F);
    chk("rst_dp", o_dp, 1'b1);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_count", o_fifo_count, 3'd0);
    chk("rst_busy", o_busy, 1'b0);
    i_reset = 1'b0;

    // Idle with no stimulus: display stays blank.
    for (int c = 0; c < 40; c++) begin
      step();
      chk("idle_anode", o_anode, 4'hF);
      chk("idle_seg", o_segments, 7'h7F);
      chk("idle_busy", o_busy, 1'b0);
    end

    // Single word: latency, then all four digits decoded.
    i_data = 16'h12AF; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("single_count", o_fifo_count, 3'd1);
    chk("single_disp_t1", dut.disp_q, 16'h0000);
    step();
    chk("single_disp_t2", dut.disp_q, 16'h12AF);
    chk("single_count_popped", o_fifo_count, 3'd0);
    step();
    scan_check(16'h12AF, 1'b0);
    chk("wait_busy", o_busy, 1'b1);
    chk("wait_disp", dut.disp_q, 16'h12AF);

    // Flush back to IDLE, then five back-to-back words in order.
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    chk("clr_busy", o_busy, 1'b0);
    step();
    chk("clr_anode", o_anode, 4'hF);
    peak = 0; last = -1; prev = dut.disp_q;
    for (int c = 0; c < 60; c++) begin
      if (c < 5) begin
        i_valid = 1'b1; i_data = 16'(c + 1); sb.push_back(16'(c + 1));
      end else begin
        i_valid = 1'b0;
      end
      step();
      if (int'(o_fifo_count) > peak) peak = int'(o_fifo_count);
      if (dut.disp_q != prev) begin
        if (sb.size() == 0) begin
          chk("seq_unexpected_word", dut.disp_q, prev);
        end else begin
          exp_w = sb.pop_front();
          chk("seq_word", dut.disp_q, exp_w);
          if (last >= 0) chk("seq_hold", 32'(c - last), 32'd8);
          last = c;
        end
      end
      prev = dut.disp_q;
    end
    chk("seq_all_shown", 32'(sb.size()), 32'd0);
    chk("seq_peak", 32'(peak), 32'd4);
    chk("seq_ovf", o_overflow, 1'b0);

    // Enter SHOW, fill FIFO, push on the hold-expiry pop, then overflow.
    i_valid = 1'b1; i_data = 16'hA000;
    step();
    i_valid = 1'b0;
    step();
    chk("show_disp", dut.disp_q, 16'hA000);
    for (int k = 1; k <= 4; k++) begin
      i_valid = 1'b1; i_data = 16'hB000 + 16'(k);
      step();
    end
    i_valid = 1'b0;
    chk("full_count", o_fifo_count, 3'd4);
    chk("full_ovf", o_overflow, 1'b0);
    step(); step(); step();
    chk("hold_last_cycle", dut.disp_q, 16'hA000);
    i_valid = 1'b1; i_data = 16'hB005;
    step();
    chk("coinc_count", o_fifo_count, 3'd4);
    chk("coinc_ovf", o_overflow, 1'b0);
    chk("coinc_disp", dut.disp_q, 16'hB001);
    i_data = 16'hB006;
    step();
    i_valid = 1'b0;
    chk("drop_ovf", o_overflow, 1'b1);
    chk("drop_count", o_fifo_count, 3'd4);
    step(); step();
    chk("ovf_sticky", o_overflow, 1'b1);

    // Clear with words queued; the word presented with it is discarded.
    i_clear = 1'b1; i_valid = 1'b1; i_data = 16'hC000;
    step();
    i_clear = 1'b0; i_valid = 1'b0;
    chk("flush_count", o_fifo_count, 3'd0);
    chk("flush_ovf", o_overflow, 1'b0);
    chk("flush_busy", o_busy, 1'b0);
    step();
    chk("flush_anode", o_anode, 4'hF);
    chk("flush_seg", o_segments, 7'h7F);
    step(); step();
    chk("flush_discard_count", o_fifo_count, 3'd0);
    chk("flush_discard_busy", o_busy, 1'b0);

    // Asynchronous reset in the middle of a scan.
    i_valid = 1'b1; i_data = 16'h1234;
    step();
    i_valid = 1'b0;
    repeat (6) step();
    chk("pre_rst_busy", o_busy, 1'b1);
    #3;
    i_reset = 1'b1;
    #1;
    chk("arst_anode", o_anode, 4'hF);
    chk("arst_seg", o_segments, 7'h7F);
    chk("arst_dp", o_dp, 1'b1);
    chk("arst_count", o_fifo_count, 3'd0);
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_disp", dut.disp_q, 16'h0000);
    step(); step();
    i_reset = 1'b0;

    // Decimal point only in digit-0 slot when the program is done.
    i_all_done = 1'b1;
    i_valid = 1'b1; i_data = 16'h0008;
    step();
    i_valid = 1'b0;
    step(); step();
    scan_check(16'h0008, 1'b1);
    i_all_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
